// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcode and RV32I funct3 encodings shared by the issue stage and ALU_unit.
`default_nettype none

package alu_pkg;

  typedef enum logic [3:0] {
    ALU_NOP  = 4'b0000,
    ALU_ADD  = 4'b0001,
    ALU_SUB  = 4'b0010,
    ALU_SLL  = 4'b0011,
    ALU_SLT  = 4'b0100,
    ALU_SLTU = 4'b0101,
    ALU_XOR  = 4'b0110,
    ALU_SRL  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_OR   = 4'b1001,
    ALU_AND  = 4'b1010
  } alu_op_e;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

endpackage

`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: maps (is_imm, funct3, funct7[5]) to a 4-bit ALU opcode plus an illegal flag.
`default_nettype none

module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic       is_imm_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output logic [3:0] ctrl_o,
  output logic       illegal_o
);

  logic [3:0] w_op;
  logic       w_bad;

  always_comb begin
    w_op  = ALU_NOP;
    w_bad = 1'b0;
    case (funct3_i)
      F3_ADD:  w_op = (!is_imm_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
      F3_SLL: begin
        w_op  = ALU_SLL;
        w_bad = funct7b5_i;
      end
      F3_SLT: begin
        w_op  = ALU_SLT;
        w_bad = funct7b5_i && !is_imm_i;
      end
      F3_SLTU: begin
        w_op  = ALU_SLTU;
        w_bad = funct7b5_i && !is_imm_i;
      end
      F3_XOR: begin
        w_op  = ALU_XOR;
        w_bad = funct7b5_i && !is_imm_i;
      end
      F3_SR:   w_op = funct7b5_i ? ALU_SRA : ALU_SRL;
      F3_OR: begin
        w_op  = ALU_OR;
        w_bad = funct7b5_i && !is_imm_i;
      end
      F3_AND: begin
        w_op  = ALU_AND;
        w_bad = funct7b5_i && !is_imm_i;
      end
      default: begin
        w_op  = ALU_NOP;
        w_bad = 1'b1;
      end
    endcase
  end

  // An undecodable instruction must never reach the ALU as a real op.
  assign ctrl_o    = w_bad ? ALU_NOP : w_op;
  assign illegal_o = w_bad;

endmodule

`default_nettype wire

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I ALU issue with RAW stall on S1, forwarding from S2, flush and illegal-op pulse.
`default_nettype none

module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_is_imm,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7b5,
  input  logic [RA_W-1:0] in_rs1,
  input  logic [RA_W-1:0] in_rs2,
  input  logic [RA_W-1:0] in_rd,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic            flush,
  input  logic [XLEN-1:0] alu_result,
  output logic [3:0]      ctrl_sig,
  output logic [XLEN-1:0] in1,
  output logic [XLEN-1:0] in2,
  output logic            wb_valid,
  output logic [RA_W-1:0] wb_rd,
  output logic            illegal_op
);

  logic [3:0]      w_dec_ctrl;
  logic            w_dec_illegal;

  logic [3:0]      ctrl_q, ctrl_d;
  logic [XLEN-1:0] in1_q, in1_d;
  logic [XLEN-1:0] in2_q, in2_d;
  logic            s1_valid_q, s1_valid_d;
  logic [RA_W-1:0] s1_rd_q, s1_rd_d;
  logic            s2_valid_q, s2_valid_d;
  logic [RA_W-1:0] s2_rd_q, s2_rd_d;
  logic            illegal_q, illegal_d;

  logic            w_stall;
  logic            w_accept;
  logic            w_fwd_rs1;
  logic            w_fwd_rs2;
  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2;

  alu_ctrl_decode u_decode (
    .is_imm_i   (in_is_imm),
    .funct3_i   (in_funct3),
    .funct7b5_i (in_funct7b5),
    .ctrl_o     (w_dec_ctrl),
    .illegal_o  (w_dec_illegal)
  );

  // S1's result does not exist yet, so a consumer of it must wait one cycle.
  assign w_stall = in_valid && s1_valid_q && (s1_rd_q != '0) &&
                   ((s1_rd_q == in_rs1) || (!in_is_imm && (s1_rd_q == in_rs2)));

  assign in_ready = rst_n && !w_stall && !flush;
  assign w_accept = in_valid && in_ready;

  assign w_fwd_rs1 = s2_valid_q && (s2_rd_q != '0) && (s2_rd_q == in_rs1);
  assign w_fwd_rs2 = s2_valid_q && (s2_rd_q != '0) && (s2_rd_q == in_rs2) && !in_is_imm;

  assign w_op1 = w_fwd_rs1 ? alu_result : in_rs1_data;
  assign w_op2 = in_is_imm ? in_imm : (w_fwd_rs2 ? alu_result : in_rs2_data);

  always_comb begin
    ctrl_d     = ALU_NOP;
    in1_d      = in1_q;
    in2_d      = in2_q;
    s1_valid_d = 1'b0;
    s1_rd_d    = s1_rd_q;
    s2_valid_d = s1_valid_q;
    s2_rd_d    = s1_rd_q;
    illegal_d  = 1'b0;
    if (flush) begin
      s2_valid_d = 1'b0;
    end else if (w_accept) begin
      if (w_dec_illegal) begin
        illegal_d = 1'b1;
      end else begin
        ctrl_d     = w_dec_ctrl;
        in1_d      = w_op1;
        in2_d      = w_op2;
        s1_valid_d = 1'b1;
        s1_rd_d    = in_rd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q     <= ALU_NOP;
      in1_q      <= '0;
      in2_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_rd_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_rd_q    <= '0;
      illegal_q  <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      in1_q      <= in1_d;
      in2_q      <= in2_d;
      s1_valid_q <= s1_valid_d;
      s1_rd_q    <= s1_rd_d;
      s2_valid_q <= s2_valid_d;
      s2_rd_q    <= s2_rd_d;
      illegal_q  <= illegal_d;
    end
  end

  assign ctrl_sig   = ctrl_q;
  assign in1        = in1_q;
  assign in2        = in2_q;
  assign wb_valid   = s2_valid_q;
  assign wb_rd      = s2_rd_q;
  assign illegal_op = illegal_q;

endmodule

`default_nettype wire

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameter XLEN, default 32: datapath width.
REQ-002 Parameter RA_W, default 5: register-address width.
REQ-003 Clock and reset: one clock `clk`; reset `rst_n` is synchronous and active-low.
REQ-004 Ports SHALL be as follows:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous active-low reset.
- `in_valid`  in  1  decoded instruction present.
- `in_ready`  out  1  instruction accepted this edge when `in_valid` is also high.
- `in_is_imm`  in  1  operand 2 comes from `in_imm`.
- `in_funct3`  in  3  RV32I funct3.
- `in_funct7b5`  in  1  RV32I funct7 bit 5.
- `in_rs1`, `in_rs2`, `in_rd`  in  RA_W  source and destination register addresses.
- `in_rs1_data`, `in_rs2_data`, `in_imm`  in  XLEN  operand values.
- `flush`  in  1  kill all in-flight work.
- `alu_result`  in  XLEN  registered ALU output, fed back for forwarding.
- `ctrl_sig`  out  4  ALU opcode, registered.
- `in1`, `in2`  out  XLEN  ALU operands, registered.
- `wb_valid`  out  1  `alu_result` is valid this cycle.
- `wb_rd`  out  RA_W  destination register for `alu_result`.
- `illegal_op`  out  1  one-cycle pulse for an undecodable instruction.

Function
REQ-005 ALU opcode map (4 bits): 0000 NOP (ALU holds its result), 0001 ADD, 0010 SUB, 0011 SLL, 0100 SLT, 0101 SLTU, 0110 XOR, 0111 SRL, 1000 SRA, 1001 OR, 1010 AND.
REQ-006 funct3 decode: 000 ADD, except SUB when `in_is_imm`=0 and `in_funct7b5`=1; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA when `in_funct7b5`=1; 110 OR; 111 AND.
REQ-007 Illegal cases:
- `in_funct7b5`=1 with funct3 outside {000, 101} when register-form.
- `in_funct7b5`=1 with funct3=001 when immediate-form.
- `in_funct7b5` is ignored for immediate-form funct3=000.
REQ-008 Pipeline tracking: stage S1 holds the instruction whose operands sit on `in1`/`in2`; stage S2 holds the instruction whose result is on `alu_result`.
REQ-009 Each stage carries a valid bit and an rd; S2 takes S1 every edge.
REQ-010 `wb_valid`/`wb_rd` SHALL equal S2 valid/rd.
REQ-011 Stall condition: `in_valid`=1, S1 valid, S1 rd != 0, and S1 rd equals `in_rs1`, or equals `in_rs2` when `in_is_imm`=0.
REQ-012 `in_ready` (combinational) = NOT stall AND NOT `flush`.
REQ-013 Forwarding: if S2 valid, S2 rd != 0 and S2 rd equals a used source register, that operand SHALL be taken from `alu_result` rather than the register data input.
REQ-014 Register x0 SHALL never stall and never forward.
REQ-015 On accept of a legal instruction, at the next edge: `ctrl_sig`/`in1`/`in2` load the decoded op and operands; S1 valid=1; S1 rd=`in_rd`.
REQ-016 `in2` SHALL be `in_imm` when immediate-form.
REQ-017 Bubble: on stall, idle, or illegal accept, the next edge loads `ctrl_sig`=0000 and S1 valid=0; `in1`/`in2` hold their values.
REQ-018 On an illegal accept, `illegal_op`=1 for exactly the following cycle and the instruction is consumed.
REQ-019 Flush takes priority over all else: the next edge clears S1 and S2 valid, loads `ctrl_sig`=0000, and accepts nothing.
REQ-020 Latency: an instruction accepted at edge N appears on `ctrl_sig`/`in*` after N; its result and `wb_valid` appear after N+1.
REQ-021 Throughput is one instruction per cycle when there is no dependency on the immediately preceding instruction.
REQ-022 The register file SHALL commit writes at the edge ending S2, so a third-following instruction reads committed data.

Reset
REQ-023 While `rst_n`=0 at an edge: `ctrl_sig`=0000, `in1`=`in2`=0, S1/S2 valid=0, `wb_rd`=0, `wb_valid`=0, `illegal_op`=0.
REQ-024 `in_ready`=0 while `rst_n`=0.
REQ-025 Reset asserted mid-stall or mid-flush SHALL discard all state.

Structure
REQ-026 Package `alu_pkg` SHALL hold the 4-bit opcode constants and the funct3 encodings, shared with `ALU_unit`.
REQ-027 Combinational sub-module `alu_ctrl_decode` SHALL map (`in_is_imm`, `in_funct3`, `in_funct7b5`) to (ctrl, illegal).
REQ-028 The hazard, forwarding and pipeline-register logic stays in `alu_issue_stage`.

Verification
REQ-029 ADD x3,x1,x2 with rs1_data=5, rs2_data=7: `ctrl_sig`=0001, `in1`=5, `in2`=7 after edge 1; `wb_valid`=1, `wb_rd`=3 after edge 2.
REQ-030 Back-to-back ADD x3,... then SUB x4,x3,x1: `in_ready`=0 for one cycle and a 0000 bubble issues; SUB then issues with `in1` taken from `alu_result` via forwarding.
REQ-031 Instruction reading x3 issued two cycles after the producer: no stall; operand forwarded from `alu_result`. With rd=x0 as producer: no stall and no forward.
REQ-032 Register-form funct3=110 with funct7b5=1: `illegal_op` pulses for one cycle, `ctrl_sig`=0000, `in_ready`=1.
REQ-033 SRAI funct3=101, funct7b5=1, imm=4: `ctrl_sig`=1000, `in2`=4. SLLI with funct7b5=1 is illegal.
REQ-034 Flush asserted with S1 and S2 valid: next cycle `wb_valid`=0, `ctrl_sig`=0000, no accept. `rst_n`=0 mid-stall: all outputs take the REQ-023 values.
